demux_1ton_stream: RTL and testbench

//   Parametrised packet-aware 1-to-N stream demultiplexer: the registered, handshaked

---
 rtl/demux_1ton_stream_if.sv | 30 +++
 rtl/demux_1ton_stream.sv | 117 +++++++++++
 tb/tb_demux_1ton_stream.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_1ton_stream_if.sv
// Stream bundle for the 1-to-N packet demux: one producer-side input stream
// and N consumer-side output channels with packed data.
interface demux_1ton_stream_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SELW = $clog2(N);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_sel;
    logic                 in_last;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic [N-1:0]         out_last;

    // Demux side
    modport slave (
        input  in_valid, in_data, in_sel, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    // Producer and consumers side
    modport master (
        output in_valid, in_data, in_sel, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/demux_1ton_stream.sv
// Packet-aware 1-to-N stream demux: channel chosen on a packet's first beat and
// held to its last beat; each channel has a one-entry output register.
module demux_1ton_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    demux_1ton_stream_if.slave   s,
    output logic                 busy,
    output logic [15:0]          drop_cnt
);
    localparam int SELW = $clog2(N);
    localparam logic [SELW:0] N_W = (SELW+1)'(N);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [SELW-1:0]      sel_q, sel_d;
    logic                 drop_q, drop_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic [N-1:0]         valid_q, valid_d;
    logic [N-1:0]         last_q, last_d;
    logic [N*WIDTH-1:0]   data_q, data_d;

    logic [SELW-1:0]      cur_sel;
    logic                 cur_drop;
    logic                 accept;
    wire  [N-1:0]         hit_w;
    wire  [N-1:0]         room_w;

    assign cur_sel  = (state_q == IDLE) ? s.in_sel : sel_q;
    assign cur_drop = (state_q == IDLE) ? ({1'b0, s.in_sel} >= N_W) : drop_q;

    // A channel can take a beat when empty or when it drains this same cycle.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign hit_w[gi]  = ~cur_drop & (cur_sel == SELW'(gi));
            assign room_w[gi] = ~valid_q[gi] | s.out_ready[gi];
        end
    endgenerate

    assign s.in_ready = cur_drop | (|(hit_w & room_w));
    assign accept     = s.in_valid & s.in_ready;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state, advancing only on accepted beats
    always_comb begin
        state_d = state_q;
        if (accept) begin
            state_d = s.in_last ? IDLE : BUSY;
        end
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == BUSY);
    end

    // Datapath next-state
    always_comb begin
        sel_d      = sel_q;
        drop_d     = drop_q;
        drop_cnt_d = drop_cnt_q;
        valid_d    = valid_q & ~s.out_ready;
        last_d     = last_q;
        data_d     = data_q;

        if (accept && state_q == IDLE) begin
            sel_d  = s.in_sel;
            drop_d = cur_drop;
        end

        if (accept && cur_drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        for (int k = 0; k < N; k++) begin
            if (accept && hit_w[k]) begin
                valid_d[k]                = 1'b1;
                last_d[k]                 = s.in_last;
                data_d[k*WIDTH +: WIDTH]  = s.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q      <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
            valid_q    <= '0;
            last_q     <= '0;
            data_q     <= '0;
        end else begin
            sel_q      <= sel_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    assign s.out_valid = valid_q;
    assign s.out_last  = last_q;
    assign s.out_data  = data_q;
    assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_demux_1ton_stream.sv
// Directed bench for demux_1ton_stream: an N=4 instance for routing, framing,
// backpressure and reset, plus an N=3 instance for invalid-select drops.
module tb_demux_1ton_stream;
    logic clk;
    logic rst;
    logic        busy4, busy3;
    logic [15:0] drop4, drop3;

    int n_tests = 0;
    int n_fail  = 0;

    demux_1ton_stream_if #(.WIDTH(8), .N(4)) if4 ();
    demux_1ton_stream_if #(.WIDTH(8), .N(3)) if3 ();

    demux_1ton_stream #(.WIDTH(8), .N(4)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .s        (if4),
        .busy     (busy4),
        .drop_cnt (drop4)
    );

    demux_1ton_stream #(.WIDTH(8), .N(3)) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .s        (if3),
        .busy     (busy3),
        .drop_cnt (drop3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
        if4.in_valid = v;
        if4.in_sel   = sel;
        if4.in_data  = d;
        if4.in_last  = l;
        if (v) $display("[TB] ch4 beat sel=%0d data=%02h last=%0b", sel, d, l);
    endtask

    task automatic drive3(input logic v, input logic [1:0] sel, input logic [7:0] d, input logic l);
        if3.in_valid = v;
        if3.in_sel   = sel;
        if3.in_data  = d;
        if3.in_last  = l;
        if (v) $display("[TB] ch3 beat sel=%0d data=%02h last=%0b", sel, d, l);
    endtask

    initial begin
        rst = 1'b1;
        drive4(1'b0, 2'd0, 8'h00, 1'b0);
        drive3(1'b0, 2'd0, 8'h00, 1'b0);
        if4.out_ready = 4'b1111;
        if3.out_ready = 3'b111;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_valid", 32'(if4.out_valid), 32'h0);
        check("rst_data",  32'(if4.out_data),  32'h0);
        check("rst_last",  32'(if4.out_last),  32'h0);
        check("rst_busy",  32'(busy4),         32'h0);
        check("rst_drop",  32'(drop4),         32'h0);

        // Single-beat packets to each channel
        for (int k = 0; k < 4; k++) begin
            drive4(1'b1, 2'(k), 8'hA0 + 8'(k), 1'b1);
            #1;
            check("sb_ready", 32'(if4.in_ready), 32'h1);
            step();
            check("sb_valid", 32'(if4.out_valid), 32'h1 << k);
            check("sb_data",  32'(if4.out_data[k*8 +: 8]), 32'hA0 + 32'(k));
            check("sb_last",  32'(if4.out_last[k]), 32'h1);
            check("sb_busy",  32'(busy4), 32'h0);
        end
        drive4(1'b0, 2'd0, 8'h00, 1'b0);
        step();
        check("sb_drain", 32'(if4.out_valid), 32'h0);

        // Four-beat packet to ch2; select changes mid-packet and is ignored
        for (int b = 0; b < 4; b++) begin
            drive4(1'b1, (b == 0) ? 2'd2 : 2'd1, 8'hB0 + 8'(b), (b == 3));
            step();
            check("pk_valid", 32'(if4.out_valid), 32'h4);
            check("pk_data",  32'(if4.out_data[23:16]), 32'hB0 + 32'(b));
            check("pk_last",  32'(if4.out_last[2]), (b == 3) ? 32'h1 : 32'h0);
            check("pk_busy",  32'(busy4), (b == 3) ? 32'h0 : 32'h1);
        end
        drive4(1'b0, 2'd0, 8'h00, 1'b0);
        step();

        // Backpressure on ch1 with no-bubble reload
        if4.out_ready = 4'b1101;
        drive4(1'b1, 2'd1, 8'hC0, 1'b1);
        step();
        check("bp_valid1", 32'(if4.out_valid), 32'h2);
        check("bp_data1",  32'(if4.out_data[15:8]), 32'hC0);
        drive4(1'b1, 2'd1, 8'hC1, 1'b1);
        #1;
        check("bp_ready_lo", 32'(if4.in_ready), 32'h0);
        step();
        check("bp_hold_v", 32'(if4.out_valid), 32'h2);
        check("bp_hold_d", 32'(if4.out_data[15:8]), 32'hC0);
        if4.out_ready = 4'b1111;
        #1;
        check("bp_ready_hi", 32'(if4.in_ready), 32'h1);
        step();
        check("bp_valid2", 32'(if4.out_valid), 32'h2);
        check("bp_data2",  32'(if4.out_data[15:8]), 32'hC1);
        drive4(1'b0, 2'd0, 8'h00, 1'b0);
        step();
        check("bp_drain", 32'(if4.out_valid), 32'h0);

        // Independence: ch0 stalled while ch1 streams
        if4.out_ready = 4'b1110;
        drive4(1'b1, 2'd0, 8'hD0, 1'b1);
        step();
        check("ind_v0", 32'(if4.out_valid), 32'h1);
        for (int b = 0; b < 3; b++) begin
            drive4(1'b1, 2'd1, 8'hE0 + 8'(b), (b == 2));
            #1;
            check("ind_ready", 32'(if4.in_ready), 32'h1);
            step();
            check("ind_valid", 32'(if4.out_valid), 32'h3);
            check("ind_d1",    32'(if4.out_data[15:8]), 32'hE0 + 32'(b));
            check("ind_d0",    32'(if4.out_data[7:0]),  32'hD0);
        end
        drive4(1'b0, 2'd0, 8'h00, 1'b0);
        step();
        check("ind_left", 32'(if4.out_valid), 32'h1);
        if4.out_ready = 4'b1111;
        step();
        check("ind_clear", 32'(if4.out_valid), 32'h0);

        // Reset mid-packet
        if4.out_ready = 4'b1100;
        drive4(1'b1, 2'd0, 8'hF0, 1'b1);
        step();
        drive4(1'b1, 2'd1, 8'hF1, 1'b0);
        step();
        drive4(1'b0, 2'd0, 8'h00, 1'b0);
        check("mr_pre_v",    32'(if4.out_valid), 32'h3);
        check("mr_pre_busy", 32'(busy4), 32'h1);
        rst = 1'b1;
        #1;
        check("mr_valid", 32'(if4.out_valid), 32'h0);
        check("mr_busy",  32'(busy4), 32'h0);
        check("mr_drop",  32'(drop4), 32'h0);
        step();
        rst = 1'b0;
        if4.out_ready = 4'b1111;
        drive4(1'b1, 2'd3, 8'h5A, 1'b0);
        step();
        check("mr_new_v",    32'(if4.out_valid), 32'h8);
        check("mr_new_d",    32'(if4.out_data[31:24]), 32'h5A);
        check("mr_new_busy", 32'(busy4), 32'h1);
        drive4(1'b1, 2'd0, 8'h5B, 1'b1);
        step();
        check("mr_end_v",    32'(if4.out_valid), 32'h8);
        check("mr_end_d",    32'(if4.out_data[31:24]), 32'h5B);
        check("mr_end_busy", 32'(busy4), 32'h0);
        drive4(1'b0, 2'd0, 8'h00, 1'b0);

        // Invalid select on N=3: three-beat dropped packet, later sel ignored
        for (int b = 0; b < 3; b++) begin
            drive3(1'b1, (b == 0) ? 2'd3 : 2'd0, 8'h70 + 8'(b), (b == 2));
            #1;
            check("dr_ready", 32'(if3.in_ready), 32'h1);
            step();
            check("dr_valid", 32'(if3.out_valid), 32'h0);
            check("dr_busy",  32'(busy3), (b == 2) ? 32'h0 : 32'h1);
        end
        check("dr_cnt3", 32'(drop3), 32'h3);

        // Drive the drop counter to saturation and past it
        $display("[TB] ch3 bulk drop of 65532 single-beat packets sel=3");
        if3.in_valid = 1'b1;
        if3.in_sel   = 2'd3;
        if3.in_last  = 1'b1;
        for (int i = 0; i < 65532; i++) @(posedge clk);
        #1;
        check("dr_sat", 32'(drop3), 32'hFFFF);
        step();
        step();
        check("dr_sat_hold", 32'(drop3), 32'hFFFF);
        check("dr_sat_v",    32'(if3.out_valid), 32'h0);
        drive3(1'b1, 2'd2, 8'h99, 1'b1);
        step();
        check("dr_after_v", 32'(if3.out_valid), 32'h4);
        check("dr_after_d", 32'(if3.out_data[23:16]), 32'h99);
        check("dr_after_c", 32'(drop3), 32'hFFFF);
        drive3(1'b0, 2'd0, 8'h00, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
